// File: rtl/fifo_rd_burst_arbiter_if.sv
// Consumer and FIFO-side signals of the read burst arbiter.
// The arbiter uses the master modport; consumers and the FIFO use the slave modport.
interface fifo_rd_burst_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int RD_DEPTH_WIDTH = 9
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      grant;
  logic                    fifo_rempty;
  logic [RD_DEPTH_WIDTH:0] fifo_rd_level;
  logic                    fifo_r_en;
  logic                    rd_vld;
  logic [2:0]              rd_owner;
  logic [NUM_REQ-1:0]      burst_done;
  logic                    busy;

  modport master (
    input  req, fifo_rempty, fifo_rd_level,
    output grant, fifo_r_en, rd_vld, rd_owner, burst_done, busy
  );

  modport slave (
    output req, fifo_rempty, fifo_rd_level,
    input  grant, fifo_r_en, rd_vld, rd_owner, burst_done, busy
  );
endinterface

// File: rtl/fifo_rd_burst_arbiter.sv
// Round-robin whole-burst scheduler for the shared FIFO read port (read clock domain).
// Define FIFO_ARB_FLUSH_EN to grant a partial burst after TIMEOUT_CYC cycles of waiting.
module fifo_rd_burst_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int RD_DEPTH_WIDTH = 9,
  parameter int BURST_LEN      = 16,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYC    = 1024
) (
  input logic                     rclk,
  input logic                     rrst_n,
  fifo_rd_burst_arbiter_if.master arb
);

  localparam int LW  = RD_DEPTH_WIDTH + 1;
  localparam int OW  = $clog2(NUM_REQ);
  localparam int OW1 = OW + 1;
  localparam logic [LW-1:0] BURST_LV = LW'(BURST_LEN);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > (2 ** RD_DEPTH_WIDTH) ||
      RD_LATENCY < 1 || RD_LATENCY > 3 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4095) begin : g_bad_param
    $error("fifo_rd_burst_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic [OW-1:0]      rr_ptr;
  logic [OW-1:0]      owner;
  logic [LW-1:0]      beat_cnt;
  logic [LW-1:0]      beat_len;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [OW-1:0]         own_pipe  [RD_LATENCY];
  logic [NUM_REQ-1:0]    done_pipe [RD_LATENCY];

  logic               rd_issue;
  logic               last_beat;
  logic               full_ok;
  logic               start;
  logic [LW-1:0]      start_len;
  logic               pick_ok;
  logic [OW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] rot_req;
  logic [OW1-1:0]     cand;

  assign rd_issue  = (state == BURST) && !arb.fifo_rempty;
  assign last_beat = rd_issue && (beat_cnt == beat_len - LW'(1));
  assign full_ok   = arb.fifo_rd_level >= BURST_LV;

  // Rotate requests so bit i is the requester i places after the RR pointer
  always_comb begin
    rot_req  = NUM_REQ'({arb.req, arb.req} >> rr_ptr);
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = OW1'(rr_ptr) + OW1'(i);
      if (cand >= OW1'(NUM_REQ)) cand = cand - OW1'(NUM_REQ);
      if (!pick_ok && rot_req[i]) begin
        pick_ok  = 1'b1;
        pick_idx = cand[OW-1:0];
      end
    end
  end

`ifdef FIFO_ARB_FLUSH_EN
  localparam logic [11:0] TIMEOUT_LV = 12'(TIMEOUT_CYC);
  logic [11:0] wait_cnt;
  logic        flush_ok;

  assign flush_ok  = (wait_cnt >= TIMEOUT_LV) && (arb.fifo_rd_level != '0);
  assign start     = pick_ok && (full_ok || flush_ok);
  assign start_len = full_ok ? BURST_LV : arb.fifo_rd_level;

  // Only counts while a partial burst sits in the FIFO and somebody is asking for it
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wait_cnt <= '0;
    end else if (state != IDLE || start || arb.req == '0 ||
                 arb.fifo_rd_level == '0 || full_ok) begin
      wait_cnt <= '0;
    end else if (wait_cnt < TIMEOUT_LV) begin
      wait_cnt <= wait_cnt + 12'd1;
    end
  end
`else
  assign start     = pick_ok && full_ok;
  assign start_len = BURST_LV;
`endif

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      beat_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= BURST;
            grant_q  <= NUM_REQ'(1) << pick_idx;
            busy_q   <= 1'b1;
            owner    <= pick_idx;
            beat_cnt <= '0;
            beat_len <= start_len;
          end
        end
        BURST: begin
          if (rd_issue) begin
            beat_cnt <= beat_cnt + LW'(1);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave only once the final beat has surfaced at the latency pipe output
          if (|done_pipe[RD_LATENCY-1]) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read latency pipe; a reset discards beats still in flight
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        own_pipe[k]  <= '0;
        done_pipe[k] <= '0;
      end
    end else begin
      for (int k = RD_LATENCY - 1; k > 0; k--) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        own_pipe[k]  <= own_pipe[k-1];
        done_pipe[k] <= done_pipe[k-1];
      end
      vld_pipe[0]  <= rd_issue;
      own_pipe[0]  <= rd_issue ? owner : '0;
      done_pipe[0] <= last_beat ? grant_q : '0;
    end
  end

  assign arb.fifo_r_en  = rd_issue;
  assign arb.grant      = grant_q;
  assign arb.busy       = busy_q;
  assign arb.rd_vld     = vld_pipe[RD_LATENCY-1];
  assign arb.rd_owner   = 3'(own_pipe[RD_LATENCY-1]);
  assign arb.burst_done = done_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_fifo_rd_burst_arbiter.sv
// Scoreboard bench for fifo_rd_burst_arbiter: directed bursts, stalls, request drops, reset, flush.
module tb_fifo_rd_burst_arbiter;
  localparam int NUM_REQ        = 2;
  localparam int RD_DEPTH_WIDTH = 9;
  localparam int BURST_LEN      = 16;
  localparam int RD_LATENCY     = 1;
  localparam int TIMEOUT_CYC    = 1024;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  fifo_rd_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .RD_DEPTH_WIDTH(RD_DEPTH_WIDTH)) arb_if ();

  fifo_rd_burst_arbiter #(
    .NUM_REQ(NUM_REQ), .RD_DEPTH_WIDTH(RD_DEPTH_WIDTH), .BURST_LEN(BURST_LEN),
    .RD_LATENCY(RD_LATENCY), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .arb(arb_if)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_owner_q[$];
  bit exp_last_q[$];
  logic [NUM_REQ-1:0] exp_grant_q[$];
  int ren_count = 0;
  int cyc_now   = 0;
  logic ren_hist = 1'b0;
  logic exp_vld;
  bit rst_at_edge = 1'b0;
  logic [NUM_REQ-1:0] prev_grant = '0;
  int mon_owner;
  bit mon_last;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out at t=%0t", name, $time);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [RD_DEPTH_WIDTH:0] level,
                               input logic rempty);
    @(posedge rclk);
    #1;
    arb_if.req           = req;
    arb_if.fifo_rd_level = level;
    arb_if.fifo_rempty   = rempty;
  endtask

  task automatic applyReset();
    rrst_n     = 1'b0;
    arb_if.req = '0;
    repeat (3) @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic pushBurst(input int owner, input int beats);
    exp_grant_q.push_back(NUM_REQ'(1) << owner);
    for (int b = 1; b <= beats; b++) begin
      exp_owner_q.push_back(owner);
      exp_last_q.push_back(b == beats);
    end
  endtask

  task automatic waitGrant(input logic [NUM_REQ-1:0] g, input int limit, output int stamp);
    int n = 0;
    while (arb_if.grant !== g && n < limit) begin
      @(negedge rclk);
      n++;
    end
    if (arb_if.grant !== g) timeoutFail("wait_grant");
    stamp = cyc_now;
  endtask

  task automatic waitDone(output int stamp);
    int n = 0;
    do begin
      @(negedge rclk);
      n++;
    end while (arb_if.burst_done == '0 && n < 400);
    if (arb_if.burst_done == '0) timeoutFail("wait_burst_done");
    stamp = cyc_now;
  endtask

  task automatic waitBeats(input int base, input int n);
    int k = 0;
    while (ren_count - base < n && k < 100) begin
      @(negedge rclk);
      k++;
    end
    if (ren_count - base < n) timeoutFail("wait_beats");
  endtask

  always @(posedge rclk) begin
    cyc_now++;
    rst_at_edge = !rrst_n;
  end

  // Monitor: latency model for rd_vld, then pop expected beats and grants
  always @(negedge rclk) begin
    exp_vld = rst_at_edge ? 1'b0 : ren_hist;
    checkOutput("rd_vld_lag", 32'(arb_if.rd_vld), 32'(exp_vld));
    ren_hist = arb_if.fifo_r_en;
    if (arb_if.rd_vld === 1'b1) begin
      if (exp_owner_q.size() == 0) begin
        timeoutFail("rd_vld_unexpected");
      end else begin
        mon_owner = exp_owner_q.pop_front();
        mon_last  = exp_last_q.pop_front();
        checkOutput("rd_owner", 32'(arb_if.rd_owner), 32'(mon_owner));
        checkOutput("burst_done", 32'(arb_if.burst_done), mon_last ? (32'd1 << mon_owner) : 32'd0);
      end
    end else if (arb_if.burst_done !== '0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL burst_done_no_vld: got 0x%0h, expected 0x0", arb_if.burst_done);
    end
    if (arb_if.grant !== prev_grant && arb_if.grant !== '0) begin
      if (exp_grant_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL grant_unexpected: got 0x%0h, expected none", arb_if.grant);
      end else begin
        checkOutput("grant", 32'(arb_if.grant), 32'(exp_grant_q.pop_front()));
      end
    end
    prev_grant = arb_if.grant;
    if (arb_if.fifo_r_en === 1'b1) ren_count++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, tg, td, ts;
    bit seen;
    arb_if.req           = '0;
    arb_if.fifo_rempty   = 1'b0;
    arb_if.fifo_rd_level = '0;

    // Reset state
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    checkOutput("rst_grant", 32'(arb_if.grant), 32'd0);
    checkOutput("rst_busy", 32'(arb_if.busy), 32'd0);
    checkOutput("rst_r_en", 32'(arb_if.fifo_r_en), 32'd0);
    checkOutput("rst_rd_vld", 32'(arb_if.rd_vld), 32'd0);
    checkOutput("rst_rd_owner", 32'(arb_if.rd_owner), 32'd0);
    checkOutput("rst_burst_done", 32'(arb_if.burst_done), 32'd0);
    @(posedge rclk);
    #1 rrst_n = 1'b1;

    // Test 1: single full burst for requester 0
    $display("[TB] test 1: single burst");
    pushBurst(0, 16);
    base = ren_count;
    applyStimulus(2'b01, 10'd16, 1'b0);
    @(negedge rclk);
    checkOutput("t1_grant_early", 32'(arb_if.grant), 32'd0);
    @(negedge rclk);
    checkOutput("t1_grant_next", 32'(arb_if.grant), 32'd1);
    checkOutput("t1_busy", 32'(arb_if.busy), 32'd1);
    tg = cyc_now;
    waitDone(td);
    arb_if.req = '0;
    checkOutput("t1_done_delay", 32'(td - tg), 32'd16);
    checkOutput("t1_beats", 32'(ren_count - base), 32'd16);
    repeat (3) @(negedge rclk);

    // Test 2: both requesting, grants alternate with one idle cycle between bursts
    $display("[TB] test 2: round robin");
    applyReset();
    pushBurst(0, 16);
    pushBurst(1, 16);
    pushBurst(0, 16);
    base = ren_count;
    applyStimulus(2'b11, 10'd16, 1'b0);
    for (int b = 0; b < 3; b++) begin
      waitGrant((b == 1) ? 2'b10 : 2'b01, 50, tg);
      waitDone(td);
      if (b == 2) arb_if.req = '0;
      checkOutput("t2_done_delay", 32'(td - tg), 32'd16);
      @(negedge rclk);
      checkOutput("t2_gap_idle", 32'(arb_if.busy), 32'd0);
      if (b < 2) begin
        @(negedge rclk);
        checkOutput("t2_regrant", 32'(arb_if.grant), (b == 0) ? 32'd2 : 32'd1);
      end
    end
    checkOutput("t2_beats", 32'(ren_count - base), 32'd48);
    repeat (3) @(negedge rclk);

    // Test 3: FIFO empties for 5 cycles mid-burst
    $display("[TB] test 3: rempty stall");
    pushBurst(0, 16);
    base = ren_count;
    applyStimulus(2'b01, 10'd16, 1'b0);
    waitGrant(2'b01, 50, tg);
    waitBeats(base, 4);
    @(posedge rclk);
    #1 arb_if.fifo_rempty = 1'b1;
    repeat (5) begin
      @(negedge rclk);
      checkOutput("t3_stall_r_en", 32'(arb_if.fifo_r_en), 32'd0);
    end
    @(posedge rclk);
    #1 arb_if.fifo_rempty = 1'b0;
    waitDone(td);
    arb_if.req = '0;
    checkOutput("t3_done_delay", 32'(td - tg), 32'd21);
    checkOutput("t3_beats", 32'(ren_count - base), 32'd16);
    repeat (3) @(negedge rclk);

    // Test 4: requester 1 drops its request after 3 beats
    $display("[TB] test 4: request dropped mid-burst");
    pushBurst(1, 16);
    base = ren_count;
    applyStimulus(2'b10, 10'd16, 1'b0);
    waitGrant(2'b10, 50, tg);
    waitBeats(base, 3);
    arb_if.req = '0;
    waitDone(td);
    checkOutput("t4_done_delay", 32'(td - tg), 32'd16);
    checkOutput("t4_beats", 32'(ren_count - base), 32'd16);
    seen = 1'b0;
    repeat (20) begin
      @(negedge rclk);
      if (arb_if.busy !== 1'b0) seen = 1'b1;
    end
    checkOutput("t4_no_regrant", 32'(seen), 32'd0);
    pushBurst(0, 16);
    applyStimulus(2'b01, 10'd16, 1'b0);
    waitGrant(2'b01, 50, tg);
    waitDone(td);
    arb_if.req = '0;
    repeat (3) @(negedge rclk);

    // Test 5: reset at beat 7 of a burst
    $display("[TB] test 5: reset mid-burst");
    pushBurst(1, 16);
    base = ren_count;
    applyStimulus(2'b11, 10'd16, 1'b0);
    waitGrant(2'b10, 50, tg);
    waitBeats(base, 7);
    rrst_n = 1'b0;
    @(negedge rclk);
    checkOutput("t5_grant", 32'(arb_if.grant), 32'd0);
    checkOutput("t5_r_en", 32'(arb_if.fifo_r_en), 32'd0);
    checkOutput("t5_rd_vld", 32'(arb_if.rd_vld), 32'd0);
    checkOutput("t5_busy", 32'(arb_if.busy), 32'd0);
    checkOutput("t5_burst_done", 32'(arb_if.burst_done), 32'd0);
    exp_owner_q.delete();
    exp_last_q.delete();
    pushBurst(0, 16);
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    waitGrant(2'b01, 50, tg);
    waitDone(td);
    arb_if.req = '0;
    checkOutput("t5_done_delay", 32'(td - tg), 32'd16);
    repeat (3) @(negedge rclk);

    // Test 6: partial burst sitting in the FIFO
    $display("[TB] test 6: partial level");
`ifdef FIFO_ARB_FLUSH_EN
    pushBurst(0, 5);
    base = ren_count;
    applyStimulus(2'b01, 10'd5, 1'b0);
    ts = cyc_now;
    waitGrant(2'b01, TIMEOUT_CYC + 100, tg);
    checkOutput("t6_flush_delay", 32'(tg - ts), 32'(TIMEOUT_CYC + 1));
    waitDone(td);
    arb_if.req = '0;
    checkOutput("t6_flush_beats", 32'(ren_count - base), 32'd5);
`else
    applyStimulus(2'b01, 10'd5, 1'b0);
    seen = 1'b0;
    repeat (4 * TIMEOUT_CYC) begin
      @(negedge rclk);
      if (arb_if.busy !== 1'b0 || arb_if.grant !== '0) seen = 1'b1;
    end
    arb_if.req = '0;
    checkOutput("t6_no_grant", 32'(seen), 32'd0);
`endif
    repeat (5) @(negedge rclk);
    checkOutput("end_beats_left", 32'(exp_owner_q.size()), 32'd0);
    checkOutput("end_grants_left", 32'(exp_grant_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
